// File: rtl/dportrom_rr_arbiter.sv
// Round-robin arbiter sharing the two read ports of a registered-read dual-port ROM among NREQ requesters.
// Optional DPROM_ARB_COALESCE_EN: requesters with the same address as a granted port ride along on that port.
module dportrom_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [NREQ*DW-1:0]   rsp_data,
    output logic [AW-1:0]        rom_addr_a,
    output logic [AW-1:0]        rom_addr_b,
    input  logic [DW-1:0]        rom_q_a,
    input  logic [DW-1:0]        rom_q_b
);

    localparam int unsigned PW = 3;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_a, gnt_b;
    logic [NREQ-1:0]   gnt_a_q, gnt_b_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [NREQ*DW-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0]     addr_a, addr_b;
    logic [AW-1:0]     addr_arr [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*AW +: AW];
        end
    end

    // Scan from ptr: first valid takes port A, next (distinct-address when coalescing) takes port B.
    always_comb begin
        logic        found_a;
        logic        found_b;
        logic [IW-1:0] idx;
        int unsigned last;
        gnt_a   = '0;
        gnt_b   = '0;
        addr_a  = '0;
        addr_b  = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        idx     = '0;
        last    = 0;
        ptr_d   = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IW'((32'(ptr_q) + k) % NREQ);
            if (req_valid[idx]) begin
                if (!found_a) begin
                    found_a    = 1'b1;
                    gnt_a[idx] = 1'b1;
                    addr_a     = addr_arr[idx];
                    last       = k;
                end
`ifdef DPROM_ARB_COALESCE_EN
                else if (addr_arr[idx] == addr_a) begin
                    gnt_a[idx] = 1'b1;
                    last       = k;
                end
`endif
                else if (!found_b) begin
                    found_b    = 1'b1;
                    gnt_b[idx] = 1'b1;
                    addr_b     = addr_arr[idx];
                    last       = k;
                end
`ifdef DPROM_ARB_COALESCE_EN
                else if (addr_arr[idx] == addr_b) begin
                    gnt_b[idx] = 1'b1;
                    last       = k;
                end
`endif
            end
        end
        if (found_a) begin
            ptr_d = PW'((32'(ptr_q) + last + 1) % NREQ);
        end
    end

    assign req_ready  = rst ? '0 : (gnt_a | gnt_b);
    assign rom_addr_a = rst ? '0 : addr_a;
    assign rom_addr_b = rst ? '0 : addr_b;

    // ROM words arrive one cycle after the accept; steer each to the slot that was granted.
    always_comb begin
        rsp_data_d = rsp_data_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_a_q[i]) begin
                rsp_data_d[i*DW +: DW] = rom_q_a;
            end else if (gnt_b_q[i]) begin
                rsp_data_d[i*DW +: DW] = rom_q_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            gnt_a_q     <= '0;
            gnt_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_a_q     <= gnt_a;
            gnt_b_q     <= gnt_b;
            rsp_valid_q <= gnt_a_q | gnt_b_q;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dportrom_rr_arbiter.sv
// Directed bench for dportrom_rr_arbiter with a registered-read ROM model rom[k] = A5A5_0000_0000_0000 | k.
module tb_dportrom_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [255:0] rsp_data;
    logic [7:0]  rom_addr_a;
    logic [7:0]  rom_addr_b;
    logic [63:0] rom_q_a;
    logic [63:0] rom_q_b;

    int n_tests;
    int n_fail;

    dportrom_rr_arbiter #(.NREQ(4), .AW(8), .DW(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rom_addr_a (rom_addr_a),
        .rom_addr_b (rom_addr_b),
        .rom_q_a    (rom_q_a),
        .rom_q_b    (rom_q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rom_word(input logic [7:0] k);
        return 64'hA5A5_0000_0000_0000 | {56'h0, k};
    endfunction

    always @(posedge clk) begin
        rom_q_a <= rom_word(rom_addr_a);
        rom_q_b <= rom_word(rom_addr_b);
    end

    function automatic logic [63:0] slot(input int i);
        return rsp_data[i*64 +: 64];
    endfunction

    task automatic set_addr(input int i, input logic [7:0] a);
        req_addr[i*8 +: 8] = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            req_addr  = $urandom;
            #1;
            n_tests++;
            if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
            n_tests++;
            if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0000", rsp_valid); end
            n_tests++;
            if (rom_addr_a !== 8'h00 || rom_addr_b !== 8'h00) begin
                n_fail++; $display("FAIL reset_rom_addr: got %h/%h exp 00/00", rom_addr_a, rom_addr_b);
            end
        end
        n_tests++;
        if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h exp 0", rsp_data); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr(i, 8'h20 + 8'(i));
        #1;
        n_tests++;
        if (req_ready !== 4'b0011) begin n_fail++; $display("FAIL release_ready: got %b exp 0011", req_ready); end
        n_tests++;
        if (rom_addr_a !== 8'h20) begin n_fail++; $display("FAIL release_addr_a: got %h exp 20", rom_addr_a); end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001;
        set_addr(0, 8'h0A);
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b exp 0001", req_ready); end
        n_tests++;
        if (rom_addr_a !== 8'h0A || rom_addr_b !== 8'h00) begin
            n_fail++; $display("FAIL single_rom_addr: got %h/%h exp 0a/00", rom_addr_a, rom_addr_b);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early: got %b exp 0000", rsp_valid); end
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_valid: got %b exp 0001", rsp_valid); end
        n_tests++;
        if (slot(0) !== 64'hA5A5_0000_0000_000A) begin
            n_fail++; $display("FAIL single_data: got %h exp a5a500000000000a", slot(0));
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_strobe_len: got %b exp 0000", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        do_reset();
        for (int n = 0; n < 6; n++) begin
            if (n < 3) begin
                req_valid = 4'b0001;
                set_addr(0, 8'h0A + 8'(n));
            end else begin
                req_valid = '0;
            end
            #1;
            exp_v = (n >= 2 && n < 5) ? 4'b0001 : 4'b0000;
            n_tests++;
            if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b exp %b", n, rsp_valid, exp_v); end
            if (exp_v != 0) begin
                n_tests++;
                if (slot(0) !== rom_word(8'h0A + 8'(n - 2))) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got %h exp %h", n, slot(0), rom_word(8'h0A + 8'(n - 2)));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_all_valid();
        logic [3:0] exp_r;
        logic [3:0] exp_v;
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr(i, 8'h10 + 8'(i));
        for (int n = 0; n < 6; n++) begin
            #1;
            exp_r = (n % 2 == 0) ? 4'b0011 : 4'b1100;
            exp_v = (n >= 2) ? exp_r : 4'b0000;
            n_tests++;
            if (req_ready !== exp_r) begin n_fail++; $display("FAIL all_ready[%0d]: got %b exp %b", n, req_ready, exp_r); end
            n_tests++;
            if (rom_addr_a !== ((n % 2 == 0) ? 8'h10 : 8'h12) || rom_addr_b !== ((n % 2 == 0) ? 8'h11 : 8'h13)) begin
                n_fail++; $display("FAIL all_rom_addr[%0d]: got %h/%h", n, rom_addr_a, rom_addr_b);
            end
            n_tests++;
            if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL all_rsp_valid[%0d]: got %b exp %b", n, rsp_valid, exp_v); end
            for (int i = 0; i < 4; i++) begin
                if (exp_v[i]) begin
                    n_tests++;
                    if (slot(i) !== rom_word(8'h10 + 8'(i))) begin
                        n_fail++; $display("FAIL all_data[%0d][%0d]: got %h exp %h", n, i, slot(i), rom_word(8'h10 + 8'(i)));
                    end
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 4'b0100;
        set_addr(2, 8'h42);
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup: got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b1001;
        set_addr(0, 8'h40);
        set_addr(3, 8'h43);
        #1;
        n_tests++;
        if (req_ready !== 4'b1001) begin n_fail++; $display("FAIL wrap_ready: got %b exp 1001", req_ready); end
        n_tests++;
        if (rom_addr_a !== 8'h43 || rom_addr_b !== 8'h40) begin
            n_fail++; $display("FAIL wrap_ports: got %h/%h exp 43/40", rom_addr_a, rom_addr_b);
        end
        @(negedge clk);
        req_valid = 4'b0011;
        set_addr(1, 8'h41);
        #1;
        n_tests++;
        if (rom_addr_a !== 8'h41 || rom_addr_b !== 8'h40) begin
            n_fail++; $display("FAIL wrap_ptr1: got %h/%h exp 41/40", rom_addr_a, rom_addr_b);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_same_addr();
        do_reset();
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) set_addr(i, 8'h05);
        #1;
`ifdef DPROM_ARB_COALESCE_EN
        n_tests++;
        if (req_ready !== 4'b0111) begin n_fail++; $display("FAIL same_ready: got %b exp 0111", req_ready); end
        n_tests++;
        if (rom_addr_a !== 8'h05 || rom_addr_b !== 8'h00) begin
            n_fail++; $display("FAIL same_ports: got %h/%h exp 05/00", rom_addr_a, rom_addr_b);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0111) begin n_fail++; $display("FAIL same_rsp: got %b exp 0111", rsp_valid); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (slot(i) !== rom_word(8'h05)) begin n_fail++; $display("FAIL same_data[%0d]: got %h", i, slot(i)); end
        end
`else
        n_tests++;
        if (req_ready !== 4'b0011) begin n_fail++; $display("FAIL same_ready0: got %b exp 0011", req_ready); end
        n_tests++;
        if (rom_addr_a !== 8'h05 || rom_addr_b !== 8'h05) begin
            n_fail++; $display("FAIL same_ports0: got %h/%h exp 05/05", rom_addr_a, rom_addr_b);
        end
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL same_ready1: got %b exp 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0011) begin n_fail++; $display("FAIL same_rsp0: got %b exp 0011", rsp_valid); end
        n_tests++;
        if (slot(0) !== rom_word(8'h05) || slot(1) !== rom_word(8'h05)) begin
            n_fail++; $display("FAIL same_data0: got %h/%h", slot(0), slot(1));
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL same_rsp1: got %b exp 0100", rsp_valid); end
        n_tests++;
        if (slot(2) !== rom_word(8'h05)) begin n_fail++; $display("FAIL same_data1: got %h", slot(2)); end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        do_reset();
        req_valid = 4'b0010;
        set_addr(1, 8'h33);
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rstfl_ready: got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rstfl_v0: got %b exp 0000", rsp_valid); end
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rstfl_v1: got %b exp 0000", rsp_valid); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rstfl_v2: got %b exp 0000", rsp_valid); end
        req_valid = 4'b1010;
        set_addr(1, 8'h31);
        set_addr(3, 8'h33);
        #1;
        n_tests++;
        if (req_ready !== 4'b1010 || rom_addr_a !== 8'h31 || rom_addr_b !== 8'h33) begin
            n_fail++; $display("FAIL rstfl_ptr: got %b %h/%h exp 1010 31/33", req_ready, rom_addr_a, rom_addr_b);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_all_valid();
        test_wrap();
        test_same_addr();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
